// File: rtl/decoder_pkg.sv
// Shared types and constants for the 3-to-8 decoder and its decode cores.
package decoder_pkg;

  localparam int SEL_W = 3;
  localparam int OUT_W = 8;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [OUT_W-1:0] onehot_t;

  localparam onehot_t ONEHOT_NONE = 8'h00;

  // Coding style used by a decode core instance.
  typedef enum logic [1:0] {
    STYLE_BOOL  = 2'd0,
    STYLE_COND  = 2'd1,
    STYLE_SHIFT = 2'd2
  } decode_style_e;

endpackage : decoder_pkg

// File: rtl/decoder_3to8_core.sv
// Combinational 3-to-8 decode; the coding style is picked at elaboration time.
// All styles implement q[i] = en & (s == i).
module decoder_3to8_core
  import decoder_pkg::*;
#(
  parameter decode_style_e STYLE = STYLE_BOOL
) (
  input  logic    en,
  input  sel_t    s,
  output onehot_t q
);

  if (STYLE == STYLE_BOOL) begin : g_bool
    // Each output is one minterm of s, gated by en.
    assign q[0] = en & ~s[2] & ~s[1] & ~s[0];
    assign q[1] = en & ~s[2] & ~s[1] &  s[0];
    assign q[2] = en & ~s[2] &  s[1] & ~s[0];
    assign q[3] = en & ~s[2] &  s[1] &  s[0];
    assign q[4] = en &  s[2] & ~s[1] & ~s[0];
    assign q[5] = en &  s[2] & ~s[1] &  s[0];
    assign q[6] = en &  s[2] &  s[1] & ~s[0];
    assign q[7] = en &  s[2] &  s[1] &  s[0];
  end else if (STYLE == STYLE_COND) begin : g_cond
    // Priority chain of ?: selecting the one-hot constant.
    assign q = !en        ? ONEHOT_NONE :
               (s == 3'd0) ? 8'h01 :
               (s == 3'd1) ? 8'h02 :
               (s == 3'd2) ? 8'h04 :
               (s == 3'd3) ? 8'h08 :
               (s == 3'd4) ? 8'h10 :
               (s == 3'd5) ? 8'h20 :
               (s == 3'd6) ? 8'h40 :
                             8'h80;
  end else begin : g_shift
    // An 8-bit operand shifted by at most 7 never loses its set bit.
    assign q = (en ? onehot_t'(8'h01) : ONEHOT_NONE) << s;
  end

endmodule : decoder_3to8_core

// File: rtl/decoder_3to8.sv
// Registered 3-to-8 decoder: three independently coded decode paths run in
// parallel, all registered on one edge, with a flag exposing any divergence.
module decoder_3to8
  import decoder_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    en,
  input  sel_t    s,
  output onehot_t q_bool,
  output onehot_t q_cond,
  output onehot_t q_shift,
  output logic    mismatch
);

  onehot_t dec_bool_p0;
  onehot_t dec_cond_p0;
  onehot_t dec_shift_p0;
  logic    mismatch_p0;

  onehot_t q_bool_p1;
  onehot_t q_cond_p1;
  onehot_t q_shift_p1;
  logic    mismatch_p1;

  decoder_3to8_core #(.STYLE(STYLE_BOOL)) u_core_bool (
    .en (en),
    .s  (s),
    .q  (dec_bool_p0)
  );

  decoder_3to8_core #(.STYLE(STYLE_COND)) u_core_cond (
    .en (en),
    .s  (s),
    .q  (dec_cond_p0)
  );

  decoder_3to8_core #(.STYLE(STYLE_SHIFT)) u_core_shift (
    .en (en),
    .s  (s),
    .q  (dec_shift_p0)
  );

  assign mismatch_p0 = (dec_bool_p0 != dec_cond_p0) | (dec_bool_p0 != dec_shift_p0);

  // Stage p0 -> p1: register all decode results and the comparison together.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_bool_p1   <= ONEHOT_NONE;
      q_cond_p1   <= ONEHOT_NONE;
      q_shift_p1  <= ONEHOT_NONE;
      mismatch_p1 <= 1'b0;
    end else begin
      q_bool_p1   <= dec_bool_p0;
      q_cond_p1   <= dec_cond_p0;
      q_shift_p1  <= dec_shift_p0;
      mismatch_p1 <= mismatch_p0;
    end
  end

  assign q_bool   = q_bool_p1;
  assign q_cond   = q_cond_p1;
  assign q_shift  = q_shift_p1;
  assign mismatch = mismatch_p1;

endmodule : decoder_3to8

// File: tb/tb_decoder_3to8.sv
// Directed and random bench for decoder_3to8 with a behavioural reference.
module tb_decoder_3to8;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] s;
  logic [7:0] q_bool;
  logic [7:0] q_cond;
  logic [7:0] q_shift;
  logic       mismatch;

  int checks;
  int errors;

  decoder_3to8 dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .s        (s),
    .q_bool   (q_bool),
    .q_cond   (q_cond),
    .q_shift  (q_shift),
    .mismatch (mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: bit i is set exactly when enabled and the select equals i;
  // reset overrides everything.
  function automatic logic [7:0] ref_dec(input logic r, input logic e, input logic [2:0] sel);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      v[i] = !r && e && (int'(sel) == i);
    end
    return v;
  endfunction

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Apply one input set, clock it in, and check all outputs after the edge.
  task automatic step(input string tag, input logic r, input logic e, input logic [2:0] sel);
    logic [7:0] exp;
    rst = r;
    en  = e;
    s   = sel;
    @(posedge clk);
    #1;
    exp = ref_dec(r, e, sel);
    chk8({tag, ".q_bool"},  q_bool,  exp);
    chk8({tag, ".q_cond"},  q_cond,  exp);
    chk8({tag, ".q_shift"}, q_shift, exp);
    chk1({tag, ".mismatch"}, mismatch, 1'b0);
  endtask

  initial begin
    logic       re;
    logic [2:0] rs;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    en  = 1'b0;
    s   = 3'd0;

    // Reset held two cycles while inputs request a decode.
    step("reset0", 1'b1, 1'b1, 3'd3);
    step("reset1", 1'b1, 1'b1, 3'd3);
    step("release", 1'b0, 1'b1, 3'd3);
    chk8("release_const", q_bool, 8'h08);

    // Disabled with the highest select.
    step("disabled", 1'b0, 1'b0, 3'd7);
    chk8("disabled_const", q_shift, 8'h00);

    // Full sweep with known one-hot constants.
    for (int i = 0; i < 8; i++) begin
      step($sformatf("sweep%0d", i), 1'b0, 1'b1, 3'(i));
      chk8($sformatf("sweep%0d_const", i), q_cond, 8'h01 << i);
    end

    // Enable toggle with s held.
    step("tog_on", 1'b0, 1'b1, 3'd5);
    chk8("tog_on_const", q_bool, 8'h20);
    step("tog_off", 1'b0, 1'b0, 3'd5);
    step("tog_on2", 1'b0, 1'b1, 3'd5);
    chk8("tog_on2_const", q_shift, 8'h20);

    // Mid-stream reset at s=4 during a sweep.
    for (int i = 0; i < 4; i++) begin
      step($sformatf("ms_sweep%0d", i), 1'b0, 1'b1, 3'(i));
    end
    step("ms_reset", 1'b1, 1'b1, 3'd4);
    chk8("ms_reset_const", q_bool, 8'h00);
    step("ms_resume", 1'b0, 1'b1, 3'd5);
    chk8("ms_resume_const", q_cond, 8'h20);

    // Random cross-check, including popcount equals en.
    for (int n = 0; n < 1000; n++) begin
      re = 1'($urandom_range(0, 1));
      rs = 3'($urandom_range(0, 7));
      step("rand", 1'b0, re, rs);
      checks++;
      assert ($countones(q_bool) == (re ? 1 : 0)) else begin
        errors++;
        $error("FAIL rand.popcount observed=%0d expected=%0d", $countones(q_bool), re ? 1 : 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_decoder_3to8
